// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 4-digit common-anode seven-segment driver.
// Captures four digits, decimal-point enables and the leading-zero mode into a
// shadow register once per frame. It then scans them one slot at a time, with
// an optional all-off window at the start of each slot.
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      synchronous active-low reset
//   i_digit0..3  digit values (0-F), digit0 rightmost
//   i_dp_en      decimal-point enable per digit
//   i_lz_blank   1 = suppress leading zeros
//   o_an         anode enables, active-low, o_an[i] low = digit i lit
//   o_seg        segments {g,f,e,d,c,b,a}, active-low
//   o_dp         decimal point, active-low
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK_CYC   = 500
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_digit0,
    input  logic [3:0] i_digit1,
    input  logic [3:0] i_digit2,
    input  logic [3:0] i_digit3,
    input  logic [3:0] i_dp_en,
    input  logic       i_lz_blank,
    output logic [3:0] o_an,
    output logic [6:0] o_seg,
    output logic       o_dp
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0]    r_p;
    logic [1:0]       r_slot;
    logic [3:0][3:0]  r_sh_digit;
    logic [3:0]       r_sh_dp;
    logic             r_sh_lz;

    logic             w_slot_end;
    logic             w_frame_end;
    logic             w_blank;
    logic [3:0]       w_sup;
    logic [3:0]       w_cur_digit;
    logic [3:0]       w_an_nxt;
    logic [6:0]       w_seg_nxt;
    logic             w_dp_nxt;

    // Hex to active-low {g..a} segment pattern
    function automatic logic [6:0] f_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign w_slot_end  = (r_p == P_LAST);
    assign w_frame_end = w_slot_end && (r_slot == 2'd3);

    // With no blank window the compare would be constant-false; drop it
    generate
        if (BLANK_CYC == 0) begin : g_noblank
            assign w_blank = 1'b0;
        end else begin : g_blank
            assign w_blank = (r_p < PW'(BLANK_CYC));
        end
    endgenerate

    // Suppression ripples down from the leftmost digit; digit0 always shows
    assign w_sup[3] = r_sh_lz && (r_sh_digit[3] == 4'h0);
    assign w_sup[2] = w_sup[3] && (r_sh_digit[2] == 4'h0);
    assign w_sup[1] = w_sup[2] && (r_sh_digit[1] == 4'h0);
    assign w_sup[0] = 1'b0;

    assign w_cur_digit = r_sh_digit[r_slot];

    // Next output values from current prescaler, slot and shadow state
    always_comb begin
        w_an_nxt  = 4'hF;
        w_seg_nxt = 7'h7F;
        w_dp_nxt  = 1'b1;
        if (!w_blank) begin
            w_an_nxt = ~(4'b0001 << r_slot);
            w_dp_nxt = ~r_sh_dp[r_slot];
            if (!w_sup[r_slot]) begin
                w_seg_nxt = f_decode(w_cur_digit);
            end
        end
    end

    // Prescaler, slot counter, frame-end shadow capture and output registers
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_p        <= '0;
            r_slot     <= 2'd0;
            r_sh_digit <= '0;
            r_sh_dp    <= 4'h0;
            r_sh_lz    <= 1'b0;
            o_an       <= 4'hF;
            o_seg      <= 7'h7F;
            o_dp       <= 1'b1;
        end else begin
            r_p <= w_slot_end ? '0 : r_p + PW'(1);
            if (w_slot_end) begin
                r_slot <= r_slot + 2'd1;
            end
            if (w_frame_end) begin
                r_sh_digit <= {i_digit3, i_digit2, i_digit1, i_digit0};
                r_sh_dp    <= i_dp_en;
                r_sh_lz    <= i_lz_blank;
            end
            o_an  <= w_an_nxt;
            o_seg <= w_seg_nxt;
            o_dp  <= w_dp_nxt;
        end
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed 4-digit seven-segment display driver, downstream of the timer digit counters (units, tens and the tens-of-seconds 0–5 counter). Each frame it captures four 4-bit BCD/hex digits into a shadow register, then time-multiplexes them onto a common-anode display. Per-slot anti-ghost blanking and optional leading-zero suppression are applied. All outputs are registered and active-low.

## Interface
- REFRESH_DIV, 50000: clk cycles per digit slot; legal range ≥ 2.
- BLANK_CYC, 500: cycles at the start of each slot with all anodes off; legal range 0 ≤ BLANK_CYC < REFRESH_DIV.
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset: sampled on the rising edge of clk, reset==0 resets the block.
- digit0  in  4  rightmost digit value (0–F).
- digit1  in  4  second digit value.
- digit2  in  4  third digit value.
- digit3  in  4  leftmost digit value.
- dp_en  in  4  decimal-point enable per digit; bit i applies to digit i.
- lz_blank  in  1  1 = suppress leading zeros.
- an  out  4  anode enables, active-low; an[i] low = digit i lit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

## Operation
- Prescaler p counts 0..REFRESH_DIV-1 and wraps to 0. Its width is clog2(REFRESH_DIV).
- Slot index i (2 bits) advances 0→1→2→3→0 on the cycle where p == REFRESH_DIV-1.
- Shadow capture: on the cycle where p == REFRESH_DIV-1 and i == 3 (frame end), these inputs are loaded into the shadow registers: digit0..3, dp_en, lz_blank. Input changes mid-frame never appear before the next frame. This prevents tearing.
- Leading-zero suppression (uses shadow values, only when shadow lz_blank == 1):
  - digit3 is suppressed if it is 0.
  - digit2 is suppressed if it is 0 and digit3 is suppressed.
  - digit1 is suppressed if it is 0 and digit2 is suppressed.
  - digit0 is never suppressed.
- A suppressed digit drives its anode low, seg = 7'h7F (all off) and dp = !dp_en[i].
- Decode is the standard hex pattern, active-low {g..a}:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30
  - 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03
  - C=7'h46, d=7'h21, E=7'h06, F=7'h0E
- Blank window: while p < BLANK_CYC, an = 4'hF, seg = 7'h7F, dp = 1.
- Otherwise, in slot i:
  - an = ~(4'b0001 << i)
  - seg = decode(shadow digit i), or suppressed as above
  - dp = !shadow dp_en[i]
- Exactly one anode is low outside the blank window. Never more than one anode is low.

## Timing
- Outputs are registered. The outputs in cycle t+1 reflect (p, i, shadow) as held in cycle t. Latency from slot change to anode change is 1 cycle.
- With BLANK_CYC = 0, there is no blank window; anodes switch directly between digits.
- Slot period is REFRESH_DIV cycles; frame period is 4·REFRESH_DIV cycles.
- A shadow capture takes effect in the first cycle of slot 0 of the next frame, i.e. in outputs one cycle after the capture edge.
- Reset (reset==0 at a clk edge), including mid-frame and during a blank window, forces on that edge:
  - p = 0, i = 0
  - shadow digits = 0, shadow dp_en = 0, shadow lz_blank = 0
  - an = 4'hF, seg = 7'h7F, dp = 1
- First frame after reset displays "0000", with no decimal points, until the first shadow capture.
- If reset is held low continuously, outputs remain at reset values; no anode is lit.

## Test plan
- Reset: assert reset=0 mid-slot 2 with an=4'b1011 -> on the next edge an=4'hF, seg=7'h7F, dp=1; after release the slot sequence restarts at i=0.
- Scan order, REFRESH_DIV=4, BLANK_CYC=1, digits 3,2,1,0 = 1,2,3,4 (captured):
  - each slot shows 1 blank cycle, then 3 cycles lit
  - slot 0: an=4'b1110, seg=7'h19
  - slot 1: an=4'b1101, seg=7'h30
  - slot 2: an=4'b1011, seg=7'h24
  - slot 3: an=4'b0111, seg=7'h79
  - frame repeats every 16 cycles
- Tearing: change digit1 from 3 to 7 mid-frame -> slot 1 keeps seg=7'h30 for the rest of that frame; the next frame shows 7'h78.
- Leading zeros: lz_blank=1, digits 3..0 = 0,0,0,0 -> slots 3,2,1 show seg=7'h7F, slot 0 shows 7'h40. With digits 3..0 = 0,5,0,9, only slot 3 is suppressed; slot 1 shows 7'h40.
- Decimal point: dp_en=4'b0100, digits 3..0 = 0,1,2,3, lz_blank=1 -> dp=0 only during slot 2's lit cycles; dp=1 in all blank windows and in all other slots.
- No-blank mode, BLANK_CYC=0, REFRESH_DIV=2 -> an rotates every 2 cycles with exactly one bit low at every cycle after the first post-reset edge; the full hex decode table 0–F is checked on digit0.
